// File: rtl/nzcv_pkg.sv
// Shared definitions for the NZCV flag stage: A64 condition codes and
// bit positions of each flag inside a packed {N,Z,C,V} nibble.
package nzcv_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001,
        CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101,
        VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001,
        GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101,
        AL = 4'b1110, NV = 4'b1111
    } cond_e;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

endpackage

// File: rtl/nzcv_flag_stage_cond_eval.sv
// Combinational A64 condition-code evaluator against a {N,Z,C,V} flag nibble.
module cond_eval
    import nzcv_pkg::*;
(
    input  cond_e      i_cond,
    input  logic [3:0] i_nzcv,
    output logic       o_true
);

    logic [3:0] code_s;
    logic       base_s;
    logic       n_s;
    logic       z_s;
    logic       c_s;
    logic       v_s;

    assign code_s = i_cond;
    assign n_s    = i_nzcv[NZCV_N];
    assign z_s    = i_nzcv[NZCV_Z];
    assign c_s    = i_nzcv[NZCV_C];
    assign v_s    = i_nzcv[NZCV_V];

    // Even codes select a base predicate; odd codes invert it, except NV which is always true.
    always_comb begin
        base_s = 1'b0;
        o_true = 1'b0;
        case (code_s[3:1])
            3'b000:  base_s = z_s;
            3'b001:  base_s = c_s;
            3'b010:  base_s = n_s;
            3'b011:  base_s = v_s;
            3'b100:  base_s = c_s & ~z_s;
            3'b101:  base_s = (n_s == v_s);
            3'b110:  base_s = ~z_s & (n_s == v_s);
            3'b111:  base_s = 1'b1;
            default: base_s = 1'b0;
        endcase
        if (code_s == NV) begin
            o_true = 1'b1;
        end else begin
            o_true = base_s ^ code_s[0];
        end
    end

endmodule

// File: rtl/nzcv_flag_stage.sv
// Flag stage after the ALU: holds architectural NZCV, evaluates conditions
// against the pre-update flags and forwards the result through a one-entry output register.
module nzcv_flag_stage
    import nzcv_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_result,
    input  logic [3:0]   i_nzcv,
    input  logic         i_set_flags,
    input  logic         i_is_cond,
    input  logic [3:0]   i_cond,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_result,
    output logic         o_cond_true,
    output logic [3:0]   o_nzcv
);

    logic       accept_s;
    logic       eval_true_s;
    logic       cond_out_s;
    logic [3:0] flags_r;

    assign o_ready  = ~o_valid | i_ready;
    assign accept_s = i_valid & o_ready;
    assign o_nzcv   = flags_r;

    // Evaluated against flags_r, i.e. the flags before this beat's own write.
    cond_eval u_cond_eval (
        .i_cond (cond_e'(i_cond)),
        .i_nzcv (flags_r),
        .o_true (eval_true_s)
    );

    // Unconditional beats always report a true condition.
    always_comb begin
        cond_out_s = 1'b1;
        if (i_is_cond) begin
            cond_out_s = eval_true_s;
        end else begin
            cond_out_s = 1'b1;
        end
    end

    // Output register, valid bit and architectural flag register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_result    <= {N{1'b0}};
            o_cond_true <= 1'b0;
            flags_r     <= 4'b0000;
        end else if (accept_s) begin
            o_valid     <= 1'b1;
            o_result    <= i_result;
            o_cond_true <= cond_out_s;
            if (i_set_flags) begin
                flags_r <= i_nzcv;
            end
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nzcv_flag_stage.sv
// Self-checking bench for nzcv_flag_stage: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the stage.
module tb_nzcv_flag_stage;

    localparam int N = 64;

    logic         clk;
    logic         rst;
    logic         vld;
    logic         o_ready;
    logic [N-1:0] res;
    logic [3:0]   nzcv;
    logic         setf;
    logic         isc;
    logic [3:0]   cnd;
    logic         o_valid;
    logic         rdy;
    logic [N-1:0] o_result;
    logic         o_cond_true;
    logic [3:0]   o_nzcv;

    int checks;
    int errors;

    // Model state.
    logic         m_valid;
    logic [N-1:0] m_result;
    logic         m_cond;
    logic [3:0]   m_flags;

    nzcv_flag_stage #(.N(N)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (vld),
        .o_ready     (o_ready),
        .i_result    (res),
        .i_nzcv      (nzcv),
        .i_set_flags (setf),
        .i_is_cond   (isc),
        .i_cond      (cnd),
        .o_valid     (o_valid),
        .i_ready     (rdy),
        .o_result    (o_result),
        .o_cond_true (o_cond_true),
        .o_nzcv      (o_nzcv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Condition table written out code by code.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic nf, zf, cf, vf;
        nf = f[3]; zf = f[2]; cf = f[1]; vf = f[0];
        case (c)
            4'd0:    return zf;
            4'd1:    return !zf;
            4'd2:    return cf;
            4'd3:    return !cf;
            4'd4:    return nf;
            4'd5:    return !nf;
            4'd6:    return vf;
            4'd7:    return !vf;
            4'd8:    return cf && !zf;
            4'd9:    return !(cf && !zf);
            4'd10:   return nf == vf;
            4'd11:   return nf != vf;
            4'd12:   return !zf && (nf == vf);
            4'd13:   return !(!zf && (nf == vf));
            default: return 1'b1;
        endcase
    endfunction

    task automatic drive(input logic r, input logic v, input logic rd, input logic [N-1:0] rs,
                         input logic [3:0] fl, input logic sf, input logic ic, input logic [3:0] cc);
        rst = r; vld = v; rdy = rd; res = rs; nzcv = fl; setf = sf; isc = ic; cnd = cc;
    endtask

    // One clock: check the combinational ready, advance the model, check registered outputs.
    task automatic step();
        logic m_ready;
        logic acc;
        #1;
        m_ready = !m_valid || rdy;
        acc     = vld && m_ready;
        if (!rst) check_value("o_ready", {63'd0, o_ready}, {63'd0, m_ready});
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_result = '0; m_cond = 1'b0; m_flags = 4'b0000;
        end else if (acc) begin
            m_cond   = isc ? ref_cond(cnd, m_flags) : 1'b1;
            m_valid  = 1'b1;
            m_result = res;
            if (setf) m_flags = nzcv;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        #1;
        check_value("o_valid", {63'd0, o_valid}, {63'd0, m_valid});
        check_value("o_result", o_result, m_result);
        check_value("o_cond_true", {63'd0, o_cond_true}, {63'd0, m_cond});
        check_value("o_nzcv", {60'd0, o_nzcv}, {60'd0, m_flags});
    endtask

    // Accept a conditional beat on the current flags and also compare with a table constant.
    task automatic cond_beat(input logic [3:0] c, input logic exp);
        drive(1'b0, 1'b1, 1'b1, 64'hC0DE, 4'b0000, 1'b0, 1'b1, c);
        step();
        check_value("cond_const", {63'd0, o_cond_true}, {63'd0, exp});
    endtask

    task automatic load_flags(input logic [3:0] f);
        drive(1'b0, 1'b1, 1'b1, 64'h0, f, 1'b1, 1'b0, 4'b0000);
        step();
    endtask

    initial begin
        checks = 0; errors = 0;
        m_valid = 1'b0; m_result = '0; m_cond = 1'b0; m_flags = 4'b0000;

        drive(1'b1, 1'b0, 1'b1, 64'h0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        step(); step();

        // Reset mid-stream while holding a beat.
        drive(1'b0, 1'b1, 1'b1, 64'hABCD, 4'b1010, 1'b1, 1'b0, 4'b0000);
        step();
        drive(1'b1, 1'b1, 1'b0, 64'h1234, 4'b1111, 1'b1, 1'b0, 4'b0000);
        step(); step();
        drive(1'b0, 1'b0, 1'b1, 64'h0, 4'b0000, 1'b0, 1'b0, 4'b0000);
        #1;
        check_value("rst_ready", {63'd0, o_ready}, 64'd1);
        check_value("rst_valid", {63'd0, o_valid}, 64'd0);
        check_value("rst_nzcv", {60'd0, o_nzcv}, 64'd0);
        check_value("rst_result", o_result, 64'd0);
        step();

        // Flag write and test in one beat sees the old flags.
        drive(1'b0, 1'b1, 1'b1, 64'h11, 4'b0100, 1'b1, 1'b1, 4'b0000);
        step();
        check_value("ccmp_old", {63'd0, o_cond_true}, 64'd0);
        check_value("ccmp_nzcv", {60'd0, o_nzcv}, 64'h4);
        cond_beat(4'b0000, 1'b1);

        // Signed comparisons.
        load_flags(4'b1001);
        cond_beat(4'b1010, 1'b1); cond_beat(4'b1011, 1'b0);
        cond_beat(4'b1100, 1'b1); cond_beat(4'b1101, 1'b0);
        load_flags(4'b1000);
        cond_beat(4'b1010, 1'b0); cond_beat(4'b1011, 1'b1);
        load_flags(4'b0110);
        cond_beat(4'b1000, 1'b0); cond_beat(4'b1001, 1'b1);

        // Backpressure with a flag-setting beat waiting.
        drive(1'b0, 1'b1, 1'b0, 64'h77, 4'b1111, 1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check_value("bp_ready", {63'd0, o_ready}, 64'd0);
            check_value("bp_nzcv", {60'd0, o_nzcv}, 64'h6);
            check_value("bp_result", o_result, 64'hC0DE);
        end
        rdy = 1'b1;
        step();
        check_value("bp_accept_nzcv", {60'd0, o_nzcv}, 64'hF);
        check_value("bp_accept_res", o_result, 64'h77);

        // Back-to-back throughput.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, 1'b1, 64'(i), 4'b0000, 1'b0, 1'b0, 4'b0101);
            step();
            check_value("tput_result", o_result, 64'(i));
            check_value("tput_valid", {63'd0, o_valid}, 64'd1);
            check_value("tput_cond", {63'd0, o_cond_true}, 64'd1);
        end

        // Every flag value against every condition code.
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                drive(1'b0, 1'b1, 1'b1, 64'(f * 16 + c), 4'b0000, 1'b0, 1'b1, 4'(c));
                step();
                if (c >= 14) check_value("al_nv", {63'd0, o_cond_true}, 64'd1);
            end
        end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  {$urandom, $urandom}, 4'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
